// File: rtl/cla_seq_adder.sv
// ---------------------------------------------------------------------------
// cla_seq_adder -- sequential W-bit adder/subtractor built around a single
// 4-bit carry-lookahead slice (cla4). One 4-bit slice is processed per clock,
// LSB first, with the carry between slices held in a register.
//
// Handshake: an operation is accepted in IDLE on in_valid && in_ready. It then
// spends NSLICE cycles in RUN, one per slice, and waits in DONE with out_valid
// high until out_ready transfers the result.
//
// Parameters
//   NSLICE     number of 4-bit slices (1..16); operand width W = 4*NSLICE
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   requester offers an operation
//   in_ready   block can accept an operation (high only in IDLE)
//   a, b       operands (unsigned or two's complement)
//   cin        carry-in for addition; ignored when sub=1
//   sub        0: a+b+cin, 1: a-b
//   out_valid  result available (high only in DONE)
//   out_ready  consumer accepts the result
//   sum        W-bit result
//   cout       carry out of the MSB (for subtraction 1 = no borrow)
//   ovf        signed overflow
//   busy       operation in progress or awaiting transfer
// ---------------------------------------------------------------------------

// 4-bit carry-lookahead adder slice: all carries from generate/propagate terms.
module cla4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c_i,
  output logic [3:0] s_o,
  output logic       c_o
);
  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;

  assign g = a_i & b_i;
  assign p = a_i ^ b_i;

  assign c[0] = c_i;
  assign c[1] = g[0] | (p[0] & c_i);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_i);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c_i);
  assign c_o  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c_i);

  assign s_o = p ^ c;
endmodule

module cla_seq_adder #(
  parameter int NSLICE = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4*NSLICE-1:0] a,
  input  logic [4*NSLICE-1:0] b,
  input  logic                cin,
  input  logic                sub,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*NSLICE-1:0] sum,
  output logic                cout,
  output logic                ovf,
  output logic                busy
);
  localparam int W  = 4 * NSLICE;
  localparam int IW = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;      // effective B: already inverted for subtraction
  logic            carry_q;
  logic [IW-1:0]   idx_q;
  logic [IW-1:0]   idx_d;
  logic [W-1:0]    sum_q;
  logic            ovf_q;
  logic            last_slice;

  // Latched operands split into 4-bit slices for the slice multiplexer.
  logic [3:0] a_sl [NSLICE];
  logic [3:0] b_sl [NSLICE];

  generate
    for (genvar gi = 0; gi < NSLICE; gi++) begin : g_slice
      assign a_sl[gi] = a_q[4*gi +: 4];
      assign b_sl[gi] = b_q[4*gi +: 4];
    end
  endgenerate

  logic [3:0] cla_a;
  logic [3:0] cla_b;
  logic [3:0] cla_s;
  logic       cla_co;

  assign cla_a = a_sl[idx_q];
  assign cla_b = b_sl[idx_q];

  cla4 u_cla4 (
    .a_i (cla_a),
    .b_i (cla_b),
    .c_i (carry_q),
    .s_o (cla_s),
    .c_o (cla_co)
  );

  assign last_slice = (idx_q == IW'(NSLICE - 1));
  // The index saturates on the final slice so it never wraps mid-operation.
  assign idx_d      = last_slice ? idx_q : idx_q + IW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            // Subtraction as A + ~B + 1: invert B and force the carry-in.
            b_q     <= sub ? ~b : b;
            carry_q <= sub | cin;
            idx_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          for (int k = 0; k < NSLICE; k++) begin
            if (idx_q == IW'(k)) begin
              sum_q[4*k +: 4] <= cla_s;
            end
          end
          carry_q <= cla_co;
          idx_q   <= idx_d;
          if (last_slice) begin
            // Overflow: operands share a sign the result does not.
            ovf_q   <= (a_q[W-1] == b_q[W-1]) && (cla_s[3] != a_q[W-1]);
            state_q <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Outputs come straight from registers or from the state decode.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign sum       = sum_q;
  assign cout      = carry_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_cla_seq_adder.sv
// ---------------------------------------------------------------------------
// tb_cla_seq_adder -- self-checking bench for cla_seq_adder (NSLICE=4, W=16).
// Directed arithmetic cases, latency, backpressure, mid-operation reset and
// 1000 random operations checked against an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_cla_seq_adder;
  localparam int NSLICE = 4;
  localparam int W      = 4 * NSLICE;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         busy;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  cla_seq_adder #(.NSLICE(NSLICE)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a_in),
    .b         (b_in),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain W+1-bit arithmetic. Returns {ovf, cout, sum}.
  function automatic logic [W+1:0] ref_model(input logic [W-1:0] aa, input logic [W-1:0] bb,
                                             input logic ci, input logic sb);
    logic [W-1:0] beff;
    logic [W:0]   full;
    logic         o;
    beff = sb ? ~bb : bb;
    full = {1'b0, aa} + {1'b0, beff} + {{W{1'b0}}, (sb ? 1'b1 : ci)};
    o    = (aa[W-1] == beff[W-1]) && (full[W-1] != aa[W-1]);
    return {o, full[W], full[W-1:0]};
  endfunction

  // Runs one operation; called just after a falling edge. Counting the accept
  // edge as the first, out_valid must rise on edge NSLICE+1. With hold>0 the
  // result is held in DONE under in_valid=1 before it is released.
  task automatic run_op(input string tag, input logic [W-1:0] aa, input logic [W-1:0] bb,
                        input logic ci, input logic sb, input logic [W-1:0] exp_sum,
                        input logic exp_cout, input logic exp_ovf, input int hold);
    chk({tag, ".in_ready_idle"}, 64'(in_ready), 64'(1));
    in_valid = 1'b1; a_in = aa; b_in = bb; cin = ci; sub = sb;
    @(posedge clk);
    @(negedge clk);
    // Scramble inputs after the accept edge; they must not matter any more.
    in_valid = 1'b0; a_in = W'($urandom); b_in = W'($urandom); cin = ~ci; sub = ~sb;
    chk({tag, ".busy_run"}, 64'(busy), 64'(1));
    chk({tag, ".in_ready_run"}, 64'(in_ready), 64'(0));
    for (int i = 1; i < NSLICE; i++) begin
      chk({tag, ".out_valid_early"}, 64'(out_valid), 64'(0));
      @(posedge clk);
      @(negedge clk);
    end
    chk({tag, ".out_valid_early"}, 64'(out_valid), 64'(0));
    @(posedge clk);
    @(negedge clk);
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(1));
    chk({tag, ".sum"}, 64'(sum), 64'(exp_sum));
    chk({tag, ".cout"}, 64'(cout), 64'(exp_cout));
    chk({tag, ".ovf"}, 64'(ovf), 64'(exp_ovf));
    $display("[TB] %s a=%h b=%h cin=%b sub=%b -> sum=%h cout=%b ovf=%b",
             tag, aa, bb, ci, sb, sum, cout, ovf);
    if (hold > 0) begin
      in_valid = 1'b1;
      for (int i = 0; i < hold; i++) begin
        a_in = W'($urandom); b_in = W'($urandom);
        @(posedge clk);
        @(negedge clk);
        chk({tag, ".hold_valid"}, 64'(out_valid), 64'(1));
        chk({tag, ".hold_in_ready"}, 64'(in_ready), 64'(0));
        chk({tag, ".hold_sum"}, 64'({ovf, cout, sum}), 64'({exp_ovf, exp_cout, exp_sum}));
      end
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, ".out_valid_after"}, 64'(out_valid), 64'(0));
    chk({tag, ".in_ready_after"}, 64'(in_ready), 64'(1));
  endtask

  logic [W+1:0] exp_q[$];
  logic [W+1:0] exp_v;
  logic         seen_valid;
  int           acc_cnt;
  int           xfer_cnt;
  int           cyc;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a_in = '0; b_in = '0; cin = 1'b0; sub = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("reset.in_ready", 64'(in_ready), 64'(1));
    chk("reset.out_valid", 64'(out_valid), 64'(0));
    chk("reset.busy", 64'(busy), 64'(0));
    chk("reset.sum", 64'(sum), 64'(0));
    chk("reset.cout", 64'(cout), 64'(0));
    chk("reset.ovf", 64'(ovf), 64'(0));
    rst = 1'b0;

    // First accept lands on the first rising edge after reset release.
    run_op("add_basic", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 0);
    run_op("add_wrap",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 0);
    run_op("add_ovf",   16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1, 0);
    run_op("sub_neg",   16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 0);
    run_op("sub_ovf",   16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 0);
    run_op("backpress", 16'hA5A5, 16'h5A5A, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 10);

    // Reset during the second RUN cycle abandons the operation.
    in_valid = 1'b1; a_in = 16'h1234; b_in = 16'h1111; cin = 1'b0; sub = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst.in_ready", 64'(in_ready), 64'(1));
    chk("midrst.out_valid", 64'(out_valid), 64'(0));
    chk("midrst.sum", 64'(sum), 64'(0));
    chk("midrst.busy", 64'(busy), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    seen_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) seen_valid = 1'b1;
    end
    chk("midrst.no_pulse", 64'(seen_valid), 64'(0));
    run_op("after_rst", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 0);

    // Random traffic: decisions made at the falling edge with outputs stable
    // until the next rising edge, so accept/transfer are known in advance.
    acc_cnt = 0; xfer_cnt = 0; cyc = 0;
    while ((acc_cnt < 1000 || exp_q.size() > 0) && cyc < 40000) begin
      in_valid  = (acc_cnt < 1000) && ($urandom_range(0, 3) != 0);
      a_in      = W'($urandom);
      b_in      = W'($urandom);
      cin       = 1'($urandom);
      sub       = 1'($urandom);
      out_ready = 1'($urandom);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("rand.spurious_result", 64'(1), 64'(0));
        end else begin
          exp_v = exp_q.pop_front();
          chk("rand.result", 64'({ovf, cout, sum}), 64'(exp_v));
          $display("[TB] rand xfer %0d sum=%h cout=%b ovf=%b", xfer_cnt, sum, cout, ovf);
        end
        xfer_cnt++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_model(a_in, b_in, cin, sub));
        acc_cnt++;
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("rand.timeout", 64'(cyc < 40000), 64'(1));
    chk("rand.accept_count", 64'(acc_cnt), 64'(1000));
    chk("rand.xfer_count", 64'(xfer_cnt), 64'(acc_cnt));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
